// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: shadow entry layout,
// forwarding-select type and the default pipeline geometry.
package pipe_ctrl_pkg;
   localparam int RFADDR_W     = 5;
   localparam int NSTAGE_N     = 3;
   localparam int LOAD_STAGE_N = 2;
   localparam int FSEL_WIDTH   = $clog2(NSTAGE_N + 1);

   typedef logic [FSEL_WIDTH-1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_RF = '0;

   typedef struct packed {
      logic                valid;
      logic [RFADDR_W-1:0] rd;
      logic                wr;
      logic                is_load;
   } pipe_entry_t;

   localparam pipe_entry_t ENTRY_NONE = '0;
endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage request / pipeline control bundle. Optional perf counters appear when
// PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if #(
   parameter int RFADDR = 5,
   parameter int NSTAGE = 3,
   parameter int FSEL_W = $clog2(NSTAGE + 1)
);
   logic              id_valid;
   logic [RFADDR-1:0] id_rs1;
   logic [RFADDR-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [RFADDR-1:0] id_rd;
   logic              id_rd_wr;
   logic              id_is_load;
   logic              br_taken;
   logic              mem_busy;
   logic              stall_if;
   logic              bubble_ex;
   logic              flush_id;
   logic              pc_redirect;
   logic [FSEL_W-1:0] fwd_rs1;
   logic [FSEL_W-1:0] fwd_rs2;
   logic [NSTAGE-1:0] stage_valid;
   logic              retire;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]       perf_cycles;
   logic [31:0]       perf_stall;
   logic [31:0]       perf_flush;
   logic [31:0]       perf_retire;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr, id_is_load,
             br_taken, mem_busy,
      input  stall_if, bubble_ex, flush_id, pc_redirect, fwd_rs1, fwd_rs2, stage_valid, retire,
             perf_cycles, perf_stall, perf_flush, perf_retire
   );
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr, id_is_load,
             br_taken, mem_busy,
      output stall_if, bubble_ex, flush_id, pc_redirect, fwd_rs1, fwd_rs2, stage_valid, retire,
             perf_cycles, perf_stall, perf_flush, perf_retire
   );
`else
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr, id_is_load,
             br_taken, mem_busy,
      input  stall_if, bubble_ex, flush_id, pc_redirect, fwd_rs1, fwd_rs2, stage_valid, retire
   );
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr, id_is_load,
             br_taken, mem_busy,
      output stall_if, bubble_ex, flush_id, pc_redirect, fwd_rs1, fwd_rs2, stage_valid, retire
   );
`endif
endinterface

// File: rtl/pipe_ctrl_fwd_match.sv
// Priority matcher for one ID source operand: picks the youngest in-flight writer
// and flags a load-use hazard when that writer's load data is not yet available.
module pipe_ctrl_fwd_match
   import pipe_ctrl_pkg::*;
#(
   parameter int RFADDR     = RFADDR_W,
   parameter int NSTAGE     = NSTAGE_N,
   parameter int LOAD_STAGE = LOAD_STAGE_N,
   parameter int FSEL_W     = $clog2(NSTAGE + 1)
) (
   input  pipe_entry_t       ent [1:NSTAGE],
   input  logic [RFADDR-1:0] rs,
   input  logic              rs_used,
   input  logic              id_valid,
   output logic [FSEL_W-1:0] sel,
   output logic              load_use
);
   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      sel      = FWD_RF;
      load_use = 1'b0;
      for (int k = NSTAGE; k >= 1; k--) begin
         if (ent[k].valid && ent[k].wr && rs_used && (ent[k].rd == rs) && (rs != '0)) begin
            sel      = FSEL_W'(k);
            load_use = ent[k].is_load && (k < LOAD_STAGE) && id_valid;
         end
      end
   end
endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/forwarding controller: shadow pipeline of dest metadata, operand forwarding
// selects, load-use stall, branch flush. Define PIPE_CTRL_PERF_EN for perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RFADDR     = RFADDR_W,
   parameter int NSTAGE     = NSTAGE_N,
   parameter int LOAD_STAGE = LOAD_STAGE_N
) (
   input  logic      clk,
   input  logic      reset,
   pipe_ctrl_if.slave bus
);
   localparam int FSEL_W = $clog2(NSTAGE + 1);

   pipe_entry_t       ent_q [1:NSTAGE];
   pipe_entry_t       ent_d [1:NSTAGE];
   logic [FSEL_W-1:0] sel_rs1, sel_rs2;
   logic              lu_rs1, lu_rs2;
   logic              load_use, redirect;
   logic              stall_raw, bubble_raw, retire_raw;

   pipe_ctrl_fwd_match #(.RFADDR(RFADDR), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .FSEL_W(FSEL_W))
      u_match_rs1 (.ent(ent_q), .rs(bus.id_rs1), .rs_used(bus.id_rs1_used), .id_valid(bus.id_valid),
                   .sel(sel_rs1), .load_use(lu_rs1));
   pipe_ctrl_fwd_match #(.RFADDR(RFADDR), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .FSEL_W(FSEL_W))
      u_match_rs2 (.ent(ent_q), .rs(bus.id_rs2), .rs_used(bus.id_rs2_used), .id_valid(bus.id_valid),
                   .sel(sel_rs2), .load_use(lu_rs2));

   // mem_busy freezes everything; a redirect kills the ID instruction, so its hazard is moot.
   always_comb begin
      load_use   = lu_rs1 | lu_rs2;
      redirect   = bus.br_taken & ent_q[1].valid;
      stall_raw  = bus.mem_busy | (!redirect & load_use);
      bubble_raw = !bus.mem_busy & (redirect | load_use);
      retire_raw = ent_q[NSTAGE].valid & !bus.mem_busy;

      bus.stall_if    = !reset & stall_raw;
      bus.bubble_ex   = !reset & bubble_raw;
      bus.flush_id    = !reset & !bus.mem_busy & redirect;
      bus.pc_redirect = !reset & !bus.mem_busy & redirect;
      bus.fwd_rs1     = reset ? '0 : sel_rs1;
      bus.fwd_rs2     = reset ? '0 : sel_rs2;
      bus.retire      = !reset & retire_raw;
      for (int k = 1; k <= NSTAGE; k++) begin
         bus.stage_valid[k-1] = !reset & ent_q[k].valid;
      end
   end

   always_comb begin
      ent_d = ent_q;
      if (!bus.mem_busy) begin
         for (int k = NSTAGE; k >= 2; k--) begin
            ent_d[k] = ent_q[k-1];
         end
         ent_d[1] = bubble_raw ? ENTRY_NONE
                               : '{valid: bus.id_valid, rd: bus.id_rd, wr: bus.id_rd_wr,
                                   is_load: bus.id_is_load};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= NSTAGE; k++) ent_q[k] <= ENTRY_NONE;
      end else begin
         ent_q <= ent_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d, ret_q, ret_d;

   always_comb begin
      cyc_d = cyc_q + 32'd1;
      stl_d = stl_q + {31'd0, stall_raw};
      fls_d = fls_q + {31'd0, !bus.mem_busy & redirect};
      ret_d = ret_q + {31'd0, retire_raw};
      bus.perf_cycles = cyc_q;
      bus.perf_stall  = stl_q;
      bus.perf_flush  = fls_q;
      bus.perf_retire = ret_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= '0;
         stl_q <= '0;
         fls_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         stl_q <= stl_d;
         fls_q <= fls_d;
         ret_q <= ret_d;
      end
   end
`endif
endmodule
